// File: rtl/maze_parallel_tx_if.sv
// Bundle of the maze parallel-port transmitter signals.
//   start/loop      : frame control from the host side
//   rd_en/rd_addr   : read request to the tile buffer
//   rd_data         : tile byte returned one cycle after rd_en
//   port_data       : parallel port data bits [7:0]
//   port_clk        : parallel port strobe (receiver bit 8)
//   port_new_frame  : first-byte marker (receiver bit 9)
//   busy/done       : transmission status
// master = transmitter, slave = host/buffer/receiver side.
interface maze_parallel_tx_if;
  logic       start;
  logic       loop;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] port_data;
  logic       port_clk;
  logic       port_new_frame;
  logic       busy;
  logic       done;

  modport master (
    input  start, loop, rd_data,
    output rd_en, rd_addr, port_data, port_clk, port_new_frame, busy, done
  );

  modport slave (
    output start, loop, rd_data,
    input  rd_en, rd_addr, port_data, port_clk, port_new_frame, busy, done
  );
endinterface

// File: rtl/maze_parallel_tx.sv
// Maze parallel-port transmitter.
// Streams NUM_BYTES tile bytes from a tile buffer onto an 8-bit parallel
// port with a software-visible strobe. Each byte takes 2 fetch cycles,
// HALF_PERIOD cycles with port_clk low, then HALF_PERIOD cycles with
// port_clk high. Data and the new-frame marker only change on entry to
// the low phase, so they are stable across every rising strobe edge.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : maze_parallel_tx_if master modport (control, buffer, port)
//   dbg_state  : current FSM state (0 IDLE, 1 FETCH, 2 SETUP, 3 HIGH)
// Handshake: start is a single-cycle request, accepted only in IDLE and
// not in the done cycle; rd_data is sampled one cycle after rd_en.
module maze_parallel_tx #(
  parameter int NUM_BYTES   = 100,
  parameter int HALF_PERIOD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  maze_parallel_tx_if.master   bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SETUP = 2'd2,
    HIGH  = 2'd3
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);
  localparam logic [7:0] HP_LAST  = 8'(HALF_PERIOD - 1);

  state_t     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rd_en_q, rd_en_d;
  logic [7:0] rd_addr_q, rd_addr_d;
  logic [7:0] port_data_q, port_data_d;
  logic       port_clk_q, port_clk_d;
  logic       new_frame_q, new_frame_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    port_data_d = port_data_q;
    port_clk_d  = port_clk_q;
    new_frame_d = new_frame_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        port_clk_d = 1'b0;
        // A start landing in the done cycle (state already IDLE) is dropped.
        if (bus.start && !done_q) begin
          state_d   = FETCH;
          idx_d     = 8'd0;
          cnt_d     = 8'd0;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = 8'd0;
        end
      end

      FETCH: begin
        // First cycle: read strobe is up. Second cycle: buffer data valid.
        if (cnt_q == 8'd0) begin
          cnt_d = 8'd1;
        end else begin
          cnt_d       = 8'd0;
          port_data_d = bus.rd_data;
          new_frame_d = (idx_q == 8'd0);
          state_d     = SETUP;
        end
      end

      SETUP: begin
        if (cnt_q == HP_LAST) begin
          cnt_d      = 8'd0;
          port_clk_d = 1'b1;
          state_d    = HIGH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      HIGH: begin
        if (cnt_q == HP_LAST) begin
          cnt_d      = 8'd0;
          port_clk_d = 1'b0;
          if (idx_q < LAST_IDX) begin
            idx_d     = idx_q + 8'd1;
            rd_en_d   = 1'b1;
            rd_addr_d = idx_q + 8'd1;
            state_d   = FETCH;
          end else begin
            done_d = 1'b1;
            if (bus.loop) begin
              idx_d     = 8'd0;
              rd_en_d   = 1'b1;
              rd_addr_d = 8'd0;
              state_d   = FETCH;
            end else begin
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 8'd0;
      cnt_q       <= 8'd0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= 8'd0;
      port_data_q <= 8'd0;
      port_clk_q  <= 1'b0;
      new_frame_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      port_data_q <= port_data_d;
      port_clk_q  <= port_clk_d;
      new_frame_q <= new_frame_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.rd_en          = rd_en_q;
  assign bus.rd_addr        = rd_addr_q;
  assign bus.port_data      = port_data_q;
  assign bus.port_clk       = port_clk_q;
  assign bus.port_new_frame = new_frame_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign dbg_state          = state_q;

endmodule

// File: doc/maze_parallel_tx.md
MAZE_PARALLEL_TX -- requirements
Module: maze_parallel_tx

Interface
REQ-001 The block SHALL have parameter NUM_BYTES, default 100, giving the bytes per transmission (10x10 maze tiles, index = y*10 + x).
REQ-002 The block SHALL have parameter HALF_PERIOD, default 8, giving the clk cycles per port_clk phase; legal range is 4..255.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous reset, active-high.
REQ-005 Port start, input, 1 bit: single-cycle request to begin one transmission.
REQ-006 Port loop, input, 1 bit: when high at end of frame, the next frame starts immediately.
REQ-007 Port rd_en, output, 1 bit: read strobe to the maze tile buffer.
REQ-008 Port rd_addr, output, 8 bits: tile buffer address, 0..NUM_BYTES-1.
REQ-009 Port rd_data, input, 8 bits: tile byte, valid exactly one cycle after rd_en.
REQ-010 Port port_data, output, 8 bits: parallel port data bits [7:0].
REQ-011 Port port_clk, output, 1 bit: parallel port strobe (receiver bit 8).
REQ-012 Port port_new_frame, output, 1 bit: first-byte marker (receiver bit 9).
REQ-013 Port busy, output, 1 bit: transmission in progress.
REQ-014 Port done, output, 1 bit: one-cycle pulse at end of each frame.

Function
REQ-015 The block SHALL use states IDLE, FETCH, SETUP and HIGH; all outputs SHALL be registered.
REQ-016 In IDLE, start=1 SHALL cause the next cycle to be FETCH with byte index 0, busy=1, rd_en=1 and rd_addr=0.
REQ-017 FETCH SHALL last exactly 2 cycles: rd_en=1 in the first cycle only, and rd_data captured at the end of the second.
REQ-018 Entering SETUP SHALL load port_data=rd_data, and port_new_frame=1 iff the index is 0, else 0.
REQ-019 SETUP SHALL hold port_clk=0 for HALF_PERIOD cycles, then HIGH SHALL hold port_clk=1 for HALF_PERIOD cycles.
REQ-020 port_data and port_new_frame SHALL change only on entry to SETUP, i.e. only while port_clk=0; they are stable for at least HALF_PERIOD+2 cycles around every port_clk rising edge.
REQ-021 The byte period SHALL be exactly 2 + 2*HALF_PERIOD clk cycles, and port_clk SHALL fall on exit from HIGH.
REQ-022 On exit from HIGH with index < NUM_BYTES-1, the block SHALL increment the index and go to FETCH.
REQ-023 On exit from HIGH with index = NUM_BYTES-1, the block SHALL pulse done=1 for one cycle.
REQ-024 In that same end-of-frame cycle, if loop=1 the block SHALL wrap the index to 0 and go to FETCH with busy held at 1.
REQ-025 In that same end-of-frame cycle, if loop=0 the block SHALL go to IDLE with busy=0.
REQ-026 start asserted while busy=1 SHALL be ignored, and SHALL NOT be queued.
REQ-027 start coincident with the done cycle SHALL be ignored; only loop controls continuation.
REQ-028 In IDLE, port_clk SHALL be 0 and port_data/port_new_frame SHALL hold their last values.
REQ-029 Index arithmetic SHALL be 8-bit unsigned, and rd_addr SHALL never exceed NUM_BYTES-1.

Reset
REQ-030 rst=1 SHALL force the state to IDLE and the index to 0.
REQ-031 rst=1 SHALL force port_clk=0, port_data=0x00, port_new_frame=0, rd_en=0, rd_addr=0, busy=0 and done=0 on the next edge.
REQ-032 rst SHALL take priority over start and over all states; a reset mid-byte SHALL truncate the frame with no further port_clk edges.
REQ-033 After reset release, the block SHALL remain in IDLE until start=1.

Verification
REQ-034 Basic frame: buffer[i]=i, HALF_PERIOD=8, pulse start -> 100 port_clk rising edges; byte k is k at its edge; port_new_frame=1 only on byte 0; done pulses exactly 1800 cycles after FETCH entry; busy then drops.
REQ-035 Back-to-back: loop=1 for two frames -> done pulses 1800 cycles apart; the second frame starts at byte 0 with port_new_frame=1; no idle gap.
REQ-036 Ignored start: pulse start at byte 37 -> no restart; the frame completes with exactly 100 bytes.
REQ-037 Reset mid-operation: assert rst during HIGH of byte 50 -> port_clk=0, busy=0, port_data=0x00 next cycle; the next start begins at byte 0 with port_new_frame=1.
REQ-038 Stability check: for every port_clk rising edge, port_data and port_new_frame are unchanged from SETUP entry until port_clk falls.
REQ-039 Loopback: connect the outputs to the base-station parallel-port receiver with HALF_PERIOD=4 and distinct random buffer contents -> the received maze memory matches the buffer for all 100 tiles.
